// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data bus,
// stalls the pipeline until completion and flags misaligned accesses.
module mem_access #(
  parameter bit TIMEOUT_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_hold,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  output logic        stallreq_mem,
  output logic        misalign_o
);

  localparam logic [7:0] ALU_LB  = 8'h20;
  localparam logic [7:0] ALU_LH  = 8'h21;
  localparam logic [7:0] ALU_LW  = 8'h22;
  localparam logic [7:0] ALU_LBU = 8'h23;
  localparam logic [7:0] ALU_LHU = 8'h24;
  localparam logic [7:0] ALU_SB  = 8'h25;
  localparam logic [7:0] ALU_SH  = 8'h26;
  localparam logic [7:0] ALU_SW  = 8'h27;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic        is_load, is_store, sext, mem_op, misaligned;
  size_t       size;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_WORD;
    case (aluop_i)
      ALU_LB:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_BYTE; end
      ALU_LH:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_HALF; end
      ALU_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      ALU_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      ALU_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      ALU_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      ALU_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      ALU_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
    mem_op     = is_load | is_store;
    misaligned = mem_op && (((size == SZ_HALF) && mem_addr_i[0]) ||
                            ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00)));

    case (size)
      SZ_BYTE: begin
        sel     = 4'b0001 << mem_addr_i[1:0];
        st_data = {4{reg2_i[7:0]}};
      end
      SZ_HALF: begin
        sel     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{reg2_i[15:0]}};
      end
      default: begin
        sel     = 4'b1111;
        st_data = reg2_i;
      end
    endcase

    ld_byte = 8'(dbus_rdata >> {mem_addr_i[1:0], 3'b000});
    ld_half = mem_addr_i[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    misalign_d   = misalign_q;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    dbus_req     = 1'b0;
    stallreq_mem = 1'b0;
    misalign_o   = 1'b0;
    dbus_we      = is_store;
    dbus_addr    = {mem_addr_i[31:2], 2'b00};
    dbus_sel     = mem_op ? sel : 4'b0000;
    dbus_wdata   = st_data;

    case (state_q)
      IDLE, BUSY: begin
        if (misaligned && state_q == IDLE) begin
          wreg_o     = 1'b0;
          misalign_o = 1'b1;
          misalign_d = 1'b1;
          state_d    = DONE;
        end else if (mem_op && !misaligned) begin
          wreg_o       = 1'b0;
          wdata_o      = '0;
          dbus_req     = 1'b1;
          stallreq_mem = 1'b1;
          misalign_d   = 1'b0;
          if (dbus_ack) begin
            rdata_d = is_load ? ld_data : '0;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (misalign_q || !is_load) begin
          wreg_o  = 1'b0;
          wdata_o = '0;
        end else begin
          wdata_o = rdata_q;
        end
        if (!stall_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset forces every output low combinationally so the bus request drops in the reset cycle.
    if (rst) begin
      state_d      = IDLE;
      wd_o         = '0;
      wreg_o       = 1'b0;
      wdata_o      = '0;
      dbus_req     = 1'b0;
      stallreq_mem = 1'b0;
      misalign_o   = 1'b0;
      dbus_we      = 1'b0;
      dbus_addr    = '0;
      dbus_sel     = '0;
      dbus_wdata   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  a_no_timeout: assert property (@(posedge clk) TIMEOUT_EN == 1'b0);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, misalignment,
// reset during a pending access and back-to-back memory ops.
module tb_mem_access;
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_LW  = 8'h22;
  localparam logic [7:0] ALU_LH  = 8'h21;
  localparam logic [7:0] ALU_LB  = 8'h20;
  localparam logic [7:0] ALU_LBU = 8'h23;
  localparam logic [7:0] ALU_LHU = 8'h24;
  localparam logic [7:0] ALU_SB  = 8'h25;
  localparam logic [7:0] ALU_SH  = 8'h26;
  localparam logic [7:0] ALU_SW  = 8'h27;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, dbus_rdata;
  logic [4:0]  wd_i;
  logic        wreg_i, stall_hold, dbus_ack;
  logic [4:0]  wd_o;
  logic        wreg_o, dbus_req, dbus_we, stallreq_mem, misalign_o;
  logic [31:0] wdata_o, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .stall_hold(stall_hold), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .stallreq_mem(stallreq_mem), .misalign_o(misalign_o)
  );

  // Inputs change just after the falling edge; outputs are checked 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; aluop_i = ALU_LW; mem_addr_i = 32'h100; reg2_i = 32'h55;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h99; stall_hold = 1'b0;
    dbus_rdata = 32'h1; dbus_ack = 1'b1;
    step(); step(); #1;
    vectors++; if (dbus_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", dbus_req); end
    vectors++; if (stallreq_mem !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b exp 0", stallreq_mem); end
    vectors++; if (wreg_o !== 1'b0) begin miscompares++; $display("FAIL rst_wreg got %b exp 0", wreg_o); end
    vectors++; if (wd_o !== 5'd0) begin miscompares++; $display("FAIL rst_wd got %h exp 0", wd_o); end
    vectors++; if (wdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h exp 0", wdata_o); end
    vectors++; if (dbus_sel !== 4'h0) begin miscompares++; $display("FAIL rst_sel got %b exp 0000", dbus_sel); end
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL rst_mis got %b exp 0", misalign_o); end
    step(); rst = 1'b0; aluop_i = ALU_ADD; dbus_ack = 1'b0;
  endtask

  task automatic test_alu_pass();
    aluop_i = ALU_ADD; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; dbus_ack = 1'b1;
    #1;
    vectors++; if (wd_o !== 5'd5) begin miscompares++; $display("FAIL alu_wd got %0d exp 5", wd_o); end
    vectors++; if (wreg_o !== 1'b1) begin miscompares++; $display("FAIL alu_wreg got %b exp 1", wreg_o); end
    vectors++; if (wdata_o !== 32'h1234) begin miscompares++; $display("FAIL alu_wdata got %h exp 00001234", wdata_o); end
    vectors++; if (dbus_req !== 1'b0) begin miscompares++; $display("FAIL alu_req got %b exp 0", dbus_req); end
    vectors++; if (stallreq_mem !== 1'b0) begin miscompares++; $display("FAIL alu_stall got %b exp 0", stallreq_mem); end
    step(); dbus_ack = 1'b0;
  endtask

  task automatic test_lb_wait();
    int stalls = 0;
    aluop_i = ALU_LB; mem_addr_i = 32'h103; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEAD;
    dbus_rdata = 32'h80FFFFFF; stall_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dbus_ack = (i == 2); #1;
      if (stallreq_mem === 1'b1) stalls++;
      vectors++; if (dbus_req !== 1'b1) begin miscompares++; $display("FAIL lb_req cyc%0d got %b exp 1", i, dbus_req); end
      vectors++; if (dbus_sel !== 4'b1000) begin miscompares++; $display("FAIL lb_sel cyc%0d got %b exp 1000", i, dbus_sel); end
      vectors++; if (wreg_o !== 1'b0) begin miscompares++; $display("FAIL lb_wreg_busy cyc%0d got %b exp 0", i, wreg_o); end
      step();
    end
    vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL lb_stall_cycles got %0d exp 3", stalls); end
    dbus_ack = 1'b0; dbus_rdata = 32'h0; stall_hold = 1'b0; #1;
    vectors++; if (stallreq_mem !== 1'b0 || dbus_req !== 1'b0) begin miscompares++; $display("FAIL lb_done_stall got %b/%b exp 0/0", stallreq_mem, dbus_req); end
    vectors++; if (wdata_o !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_wdata got %h exp ffffff80", wdata_o); end
    vectors++; if (wreg_o !== 1'b1 || wd_o !== 5'd3) begin miscompares++; $display("FAIL lb_wreg got %b/%0d exp 1/3", wreg_o, wd_o); end
    step(); aluop_i = ALU_ADD;
  endtask

  task automatic test_lhu_zero_wait();
    aluop_i = ALU_LHU; mem_addr_i = 32'h102; wd_i = 5'd9; wreg_i = 1'b1;
    dbus_rdata = 32'hBEEF0000; dbus_ack = 1'b1; #1;
    vectors++; if (dbus_req !== 1'b1 || stallreq_mem !== 1'b1) begin miscompares++; $display("FAIL lhu_req got %b/%b exp 1/1", dbus_req, stallreq_mem); end
    vectors++; if (dbus_sel !== 4'b1100) begin miscompares++; $display("FAIL lhu_sel got %b exp 1100", dbus_sel); end
    step(); dbus_ack = 1'b0; dbus_rdata = 32'h0; #1;
    vectors++; if (stallreq_mem !== 1'b0) begin miscompares++; $display("FAIL lhu_stall_len got %b exp 0", stallreq_mem); end
    vectors++; if (wdata_o !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_wdata got %h exp 0000beef", wdata_o); end
    step();
    aluop_i = ALU_LH; mem_addr_i = 32'h200; dbus_rdata = 32'h0000F00D; dbus_ack = 1'b1;
    step(); dbus_ack = 1'b0; #1;
    vectors++; if (wdata_o !== 32'hFFFFF00D) begin miscompares++; $display("FAIL lh_sext got %h exp fffff00d", wdata_o); end
    step(); aluop_i = ALU_ADD;
  endtask

  task automatic test_store();
    aluop_i = ALU_SH; mem_addr_i = 32'h22; reg2_i = 32'hAABBCCDD; wreg_i = 1'b1; dbus_ack = 1'b1; #1;
    vectors++; if (dbus_addr !== 32'h20) begin miscompares++; $display("FAIL sh_addr got %h exp 00000020", dbus_addr); end
    vectors++; if (dbus_sel !== 4'b1100) begin miscompares++; $display("FAIL sh_sel got %b exp 1100", dbus_sel); end
    vectors++; if (dbus_wdata !== 32'hCCDDCCDD) begin miscompares++; $display("FAIL sh_wdata got %h exp ccddccdd", dbus_wdata); end
    vectors++; if (dbus_we !== 1'b1 || dbus_req !== 1'b1) begin miscompares++; $display("FAIL sh_we_req got %b/%b exp 1/1", dbus_we, dbus_req); end
    step(); dbus_ack = 1'b0; #1;
    vectors++; if (wreg_o !== 1'b0) begin miscompares++; $display("FAIL sh_done_wreg got %b exp 0", wreg_o); end
    step();
    aluop_i = ALU_SB; mem_addr_i = 32'h21; reg2_i = 32'h1234565A; dbus_ack = 1'b1; #1;
    vectors++; if (dbus_sel !== 4'b0010) begin miscompares++; $display("FAIL sb_sel got %b exp 0010", dbus_sel); end
    vectors++; if (dbus_wdata !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL sb_wdata got %h exp 5a5a5a5a", dbus_wdata); end
    step(); dbus_ack = 1'b0; step(); aluop_i = ALU_ADD;
  endtask

  task automatic test_misalign();
    aluop_i = ALU_LW; mem_addr_i = 32'h101; wreg_i = 1'b1; stall_hold = 1'b1; dbus_ack = 1'b1; #1;
    vectors++; if (dbus_req !== 1'b0 || stallreq_mem !== 1'b0) begin miscompares++; $display("FAIL mis_req got %b/%b exp 0/0", dbus_req, stallreq_mem); end
    vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL mis_flag got %b exp 1", misalign_o); end
    vectors++; if (wreg_o !== 1'b0) begin miscompares++; $display("FAIL mis_wreg got %b exp 0", wreg_o); end
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL mis_repeat cyc%0d got %b exp 0", i, misalign_o); end
      vectors++; if (wreg_o !== 1'b0) begin miscompares++; $display("FAIL mis_done_wreg cyc%0d got %b exp 0", i, wreg_o); end
    end
    stall_hold = 1'b0; step();
    aluop_i = ALU_LH; mem_addr_i = 32'h103; #1;
    vectors++; if (misalign_o !== 1'b1 || dbus_req !== 1'b0) begin miscompares++; $display("FAIL mis_lh got %b/%b exp 1/0", misalign_o, dbus_req); end
    step(); step(); aluop_i = ALU_ADD; dbus_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    aluop_i = ALU_LW; mem_addr_i = 32'h40; dbus_ack = 1'b0; stall_hold = 1'b1;
    step(); #1;
    vectors++; if (dbus_req !== 1'b1) begin miscompares++; $display("FAIL rb_busy_req got %b exp 1", dbus_req); end
    rst = 1'b1; #1;
    vectors++; if (dbus_req !== 1'b0 || stallreq_mem !== 1'b0) begin miscompares++; $display("FAIL rb_drop got %b/%b exp 0/0", dbus_req, stallreq_mem); end
    step(); rst = 1'b0; aluop_i = ALU_ADD; wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h77; #1;
    vectors++; if (wreg_o !== 1'b1 || wdata_o !== 32'h77 || dbus_req !== 1'b0) begin miscompares++; $display("FAIL rb_idle got %b/%h/%b exp 1/00000077/0", wreg_o, wdata_o, dbus_req); end
    step();
    aluop_i = ALU_SW; mem_addr_i = 32'h44; reg2_i = 32'h11223344; dbus_ack = 1'b1; #1;
    vectors++; if (dbus_req !== 1'b1 || dbus_sel !== 4'b1111 || dbus_wdata !== 32'h11223344 || dbus_we !== 1'b1) begin
      miscompares++; $display("FAIL rb_sw got req%b sel%b wd%h we%b exp req1 sel1111 wd11223344 we1", dbus_req, dbus_sel, dbus_wdata, dbus_we); end
    step(); dbus_ack = 1'b0; #1;
    vectors++; if (stallreq_mem !== 1'b0 || wreg_o !== 1'b0) begin miscompares++; $display("FAIL rb_sw_done got %b/%b exp 0/0", stallreq_mem, wreg_o); end
    stall_hold = 1'b0; step(); aluop_i = ALU_ADD;
  endtask

  task automatic test_back_to_back();
    aluop_i = ALU_LW; mem_addr_i = 32'h8; wreg_i = 1'b1; dbus_rdata = 32'hCAFEF00D; dbus_ack = 1'b1; stall_hold = 1'b0;
    step(); #1;
    vectors++; if (wdata_o !== 32'hCAFEF00D || dbus_req !== 1'b0) begin miscompares++; $display("FAIL b2b_first got %h/%b exp cafef00d/0", wdata_o, dbus_req); end
    step();
    aluop_i = ALU_LBU; mem_addr_i = 32'h9; #1;
    vectors++; if (dbus_req !== 1'b1 || dbus_sel !== 4'b0010) begin miscompares++; $display("FAIL b2b_req got %b/%b exp 1/0010", dbus_req, dbus_sel); end
    step(); dbus_ack = 1'b0; #1;
    vectors++; if (wdata_o !== 32'h000000F0) begin miscompares++; $display("FAIL b2b_lbu got %h exp 000000f0", wdata_o); end
    step(); aluop_i = ALU_ADD;
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lb_wait();
    test_lhu_zero_wait();
    test_store();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline. Consumes the registered EX/MEM outputs (aluop, effective address, store data, destination register, write enable, ALU result) and drives the MEM/WB inputs. It performs LB/LH/LW/LBU/LHU/SB/SH/SW through a request/acknowledge data bus and holds the pipeline via `stallreq_mem` until the access completes.

## Interface
- `TIMEOUT_EN`, default 0: reserved, must be 0; no timeout logic.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `aluop_i` in `AluOpBus`: operation code from EX/MEM; load/store codes come from the shared defines file.
- `mem_addr_i` in 32: effective byte address.
- `reg2_i` in 32: store data (rs2).
- `wd_i` in 5: destination register.
- `wreg_i` in 1: register write enable.
- `wdata_i` in 32: ALU result for non-memory ops.
- `stall_hold` in 1: ctrl `stall[4]`; high means MEM/WB does not advance this cycle.
- `dbus_rdata` in 32: read data, valid when `dbus_ack` is high.
- `dbus_ack` in 1: bus completion, one cycle per request.
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32: outputs to MEM/WB.
- `dbus_req` out 1: bus request.
- `dbus_we` out 1: 1 = store.
- `dbus_addr` out 32: word-aligned address, `{mem_addr_i[31:2],2'b00}`.
- `dbus_sel` out 4: byte-lane enables, little-endian; bit0 = byte 0.
- `dbus_wdata` out 32: store data replicated into lanes.
- `stallreq_mem` out 1: stall request to ctrl.
- `misalign_o` out 1: misaligned-access flag, one cycle per offending instruction.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: state, `rdata_q` (32), `misalign_q`.
- Non-memory aluop in IDLE: `wd_o/wreg_o/wdata_o` equal the inputs, combinationally. `dbus_req`=0, `stallreq_mem`=0.
- Memory aluop, aligned, in IDLE or BUSY:
  - `dbus_req`=1 and `stallreq_mem`=1, both combinational.
  - `wreg_o`=0.
  - Enter BUSY on the edge when ack=0. Stay in BUSY while ack=0.
  - On the edge with ack=1, go to DONE and capture `rdata_q` from the extracted load data.
- DONE:
  - `dbus_req`=0, `stallreq_mem`=0.
  - Loads: `wreg_o`=`wreg_i`, `wdata_o`=`rdata_q`.
  - Stores: `wreg_o`=0, `wdata_o`=0.
  - Return to IDLE on the edge with `stall_hold`=0; otherwise stay in DONE with no re-issue.
- Lane select:
  - Byte access: `sel` = one-hot of `addr[1:0]`.
  - Half access: `sel` = 0011 if `addr[1]`=0, else 1100.
  - Word access: `sel` = 1111.
- Store data: SB = `{4{reg2[7:0]}}`; SH = `{2{reg2[15:0]}}`; SW = `reg2`.
- Load extraction: select the addressed byte or half from `dbus_rdata`. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned access (half with `addr[0]`=1, word with `addr[1:0]`≠0):
  - No bus request, no stall, `wreg_o`=0.
  - `misalign_o`=1 in IDLE; go to DONE so the flag is not repeated while `stall_hold` is high.
  - `misalign_o`=0 in DONE.
- Unknown aluop: treated as non-memory.

## Timing
- Reset: state=IDLE, `rdata_q`=0. Every output is 0 while `rst`=1, including `dbus_req`, `stallreq_mem`, `wreg_o`, `wd_o`, `wdata_o`, `sel`, `misalign_o`.
- Ack may arrive in the same cycle as the first `dbus_req`.
  - Minimum stall is 1 cycle: request cycle N, DONE in N+1, MEM/WB latches at the end of N+1.
  - Ack after k wait cycles gives k+1 stall cycles.
- `dbus_addr`, `dbus_we`, `dbus_sel`, `dbus_wdata` are stable while `dbus_req`=1, because ctrl freezes EX/MEM during stall.
- `dbus_ack` is ignored when `dbus_req`=0, i.e. in DONE or IDLE with a non-memory op.
- Reset during BUSY: return to IDLE, `dbus_req` drops in the same cycle. The slave aborts on `req` deassertion. Late acks are not tracked.
- Back-to-back memory ops: DONE→IDLE, then the new request in the next cycle. No idle bus cycle is required beyond DONE.

## Test plan
- ALU pass-through: aluop=ADD, wd=5, wreg=1, wdata=0x1234 → outputs identical the same cycle; req=0, stallreq=0.
- LB, 2-cycle wait: addr=0x103, rdata=0x80FFFFFF, ack on the 3rd request cycle → sel=1000; stallreq high 3 cycles; DONE `wdata_o`=0xFFFFFF80, wreg=1.
- LHU, zero wait: addr=0x102, rdata=0xBEEF0000, ack same cycle → stall 1 cycle; `wdata_o`=0x0000BEEF.
- SH: addr=0x22, reg2=0xAABBCCDD → dbus_addr=0x20, sel=1100, wdata=0xCCDDCCDD, we=1; DONE wreg_o=0.
- Misaligned LW at addr=0x101 → req=0, stallreq=0, `misalign_o` 1 for one cycle, wreg_o=0; `stall_hold` held 2 cycles → no second pulse.
- Reset in BUSY: rst=1 after 1 wait cycle → req=0, stallreq=0, state IDLE. A subsequent SW with ack completes normally.
